arm_mc_controller: RTL and testbench

Parametrised multicycle ARM control unit: main FSM, instruction decoder, ALU decoder and conditional-execution logic with an architectural NZCV flags register. It drives the multicycle datapath (PC, IR, register file, ALU, shared instruction/data memory). It is the successor to the fixed 2-bit-ALUControl controller and adds:
- a selectable extended ALU operation set;
- a memory-ready handshake for wait-stated memory;
- the full ARM condition-code set.

---
 rtl/arm_mc_pkg.sv | 53 +++++
 rtl/arm_cond_unit.sv | 51 +++++
 rtl/arm_mc_controller.sv | 196 +++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle ARM controller.
// State encoding, ALU operation codes, opcode and condition fields.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flags register and condition-code evaluation.
// Logic ops update only N,Z, so the two halves have separate enables.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       write_nz,
  input  logic       write_cv,
  output logic       cond_ex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (write_nz) flags[3:2] <= alu_flags[3:2];
      if (write_cv) flags[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      CC_EQ: cond_ex = z;
      CC_NE: cond_ex = ~z;
      CC_CS: cond_ex = c;
      CC_CC: cond_ex = ~c;
      CC_MI: cond_ex = n;
      CC_PL: cond_ex = ~n;
      CC_VS: cond_ex = v;
      CC_VC: cond_ex = ~v;
      CC_HI: cond_ex = c & ~z;
      CC_LS: cond_ex = ~c | z;
      CC_GE: cond_ex = (n == v);
      CC_LT: cond_ex = (n != v);
      CC_GT: cond_ex = ~z & (n == v);
      CC_LE: cond_ex = z | (n != v);
      CC_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction and ALU decode.
// Write strobes are gated by the condition check and memory ready.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 2,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  localparam bit EXT = (ALUCTRL_W >= 3);

  state_t state, next;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       imm, s_bit, l_bit, rdy;
  logic       cond_ex, flag_upd;
  logic       dp_write, cmp, logic_op;
  logic [ALUCTRL_W-1:0] alu_op, alu_ctl;
  logic       unused;

  assign cond   = Instr[19:16];
  assign op     = Instr[15:14];
  assign imm    = Instr[13];
  assign cmd    = Instr[12:9];
  assign s_bit  = Instr[8];
  assign l_bit  = Instr[8];
  assign unused = ^Instr[7:0];
  assign rdy    = MEM_WAIT_EN ? MemReady : 1'b1;

  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign State  = reset ? FETCH : state;
  assign ALUControl = alu_ctl;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:    if (rdy) next = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  next = MEMADR;
          OP_DP:   next = imm ? EXECI : EXECR;
          OP_BR:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR:   next = l_bit ? MEMREAD : MEMWRITE;
      MEMREAD:  if (rdy) next = MEMWB;
      MEMWRITE: if (rdy) next = FETCH;
      EXECR,
      EXECI:    next = ALUWB;
      default:  next = FETCH;
    endcase
  end

  // Unsupported commands fall back to ADD with no register write.
  always_comb begin
    alu_op   = ALUCTRL_W'(ALU_ADD);
    dp_write = 1'b0;
    cmp      = 1'b0;
    logic_op = 1'b0;
    case (cmd)
      CMD_ADD: dp_write = 1'b1;
      CMD_SUB: begin
        alu_op   = ALUCTRL_W'(ALU_SUB);
        dp_write = 1'b1;
      end
      CMD_AND: begin
        alu_op   = ALUCTRL_W'(ALU_AND);
        dp_write = 1'b1;
        logic_op = 1'b1;
      end
      CMD_ORR: begin
        alu_op   = ALUCTRL_W'(ALU_ORR);
        dp_write = 1'b1;
        logic_op = 1'b1;
      end
      CMD_EOR: begin
        if (EXT) begin
          alu_op   = ALUCTRL_W'(ALU_EOR);
          dp_write = 1'b1;
          logic_op = 1'b1;
        end
      end
      CMD_CMP: begin
        if (EXT) begin
          alu_op = ALUCTRL_W'(ALU_SUB);
          cmp    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_ctl   = ALUCTRL_W'(ALU_ADD);
    flag_upd  = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCWrite   = rdy;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      EXECI: begin
        ALUSrcB  = 2'b01;
        alu_ctl  = alu_op;
        flag_upd = s_bit | cmp;
      end
      EXECR: begin
        alu_ctl  = alu_op;
        flag_upd = s_bit | cmp;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
      end
      ALUWB:    RegWrite = cond_ex & dp_write;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    // Under reset present a quiet FETCH regardless of the held state.
    if (reset) begin
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b01;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
      alu_ctl   = ALUCTRL_W'(ALU_ADD);
      flag_upd  = 1'b0;
    end
  end

  arm_cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .write_nz  (flag_upd & cond_ex),
    .write_cv  (flag_upd & cond_ex & ~logic_op),
    .cond_ex   (cond_ex)
  );

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller, 2-bit and 3-bit ALU variants.
// An instruction-level model queues per-cycle expectations; a monitor checks.
module tb_arm_mc_controller;
  import arm_mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, mw, rw, iw, adr;
    logic [1:0] rs, sa, sb, res, imm;
    logic [2:0] ac;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b1;
  logic [19:0] instr = 20'hE0855;
  logic [3:0]  alu_flags = 4'h0;

  logic       a_pcw, a_mw, a_rw, a_iw, a_adr;
  logic [1:0] a_rs, a_sa, a_sb, a_res, a_imm, a_ac;
  logic [3:0] a_st;
  logic       b_pcw, b_mw, b_rw, b_iw, b_adr;
  logic [1:0] b_rs, b_sa, b_sb, b_res, b_imm;
  logic [2:0] b_ac;
  logic [3:0] b_st;

  obs_t act2, act3;
  obs_t q2[$], q3[$];
  logic [3:0] fl2 = 4'h0, fl3 = 4'h0;
  int tests = 0, fails = 0, cyc_no = 0;

  always #5 clk = ~clk;

  arm_mc_controller #(.ALUCTRL_W(2), .MEM_WAIT_EN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .MemReady(mem_ready), .PCWrite(a_pcw), .MemWrite(a_mw),
    .RegWrite(a_rw), .IRWrite(a_iw), .AdrSrc(a_adr), .RegSrc(a_rs),
    .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ResultSrc(a_res), .ImmSrc(a_imm),
    .ALUControl(a_ac), .State(a_st)
  );

  arm_mc_controller #(.ALUCTRL_W(3), .MEM_WAIT_EN(1'b1)) dut3 (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .MemReady(mem_ready), .PCWrite(b_pcw), .MemWrite(b_mw),
    .RegWrite(b_rw), .IRWrite(b_iw), .AdrSrc(b_adr), .RegSrc(b_rs),
    .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ResultSrc(b_res), .ImmSrc(b_imm),
    .ALUControl(b_ac), .State(b_st)
  );

  assign act2 = {a_st, a_pcw, a_mw, a_rw, a_iw, a_adr,
                 a_rs, a_sa, a_sb, a_res, a_imm, 1'b0, a_ac};
  assign act3 = {b_st, b_pcw, b_mw, b_rw, b_iw, b_adr,
                 b_rs, b_sa, b_sb, b_res, b_imm, b_ac};

  function automatic logic passes(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t model(int w, state_t ph, logic [19:0] ins,
                                 logic [3:0] f, logic rdy, logic rst);
    obs_t o;
    logic [1:0] op;
    logic [3:0] cmd;
    logic ok, ext, wr;
    logic [2:0] ac;
    o = '0;
    op = ins[15:14];
    cmd = ins[12:9];
    ok = passes(ins[19:16], f);
    ext = (w == 3);
    ac = 3'd0;
    wr = 1'b0;
    if (cmd == 4'b0100) wr = 1'b1;
    else if (cmd == 4'b0010) begin ac = 3'd1; wr = 1'b1; end
    else if (cmd == 4'b0000) begin ac = 3'd2; wr = 1'b1; end
    else if (cmd == 4'b1100) begin ac = 3'd3; wr = 1'b1; end
    else if (ext && cmd == 4'b0001) begin ac = 3'd4; wr = 1'b1; end
    else if (ext && cmd == 4'b1010) ac = 3'd1;
    o.imm = op;
    o.rs = {op == 2'b01, op == 2'b10};
    o.st = ph;
    if (rst) begin
      o.st = 4'd0;
      o.sa = 2'b01; o.sb = 2'b10; o.res = 2'b10;
      return o;
    end
    case (ph)
      FETCH: begin
        o.sa = 2'b01; o.sb = 2'b10; o.res = 2'b10;
        o.iw = rdy; o.pcw = rdy;
      end
      DECODE:   begin o.sa = 2'b01; o.sb = 2'b10; o.res = 2'b10; end
      MEMADR:   o.sb = 2'b01;
      EXECI:    begin o.sb = 2'b01; o.ac = ac; end
      EXECR:    o.ac = ac;
      MEMREAD:  o.adr = 1'b1;
      MEMWRITE: begin o.adr = 1'b1; o.mw = ok; end
      MEMWB:    begin o.res = 2'b01; o.rw = ok; end
      ALUWB:    o.rw = ok && wr;
      BRANCH: begin
        o.sa = 2'b10; o.sb = 2'b01; o.res = 2'b10; o.pcw = ok;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] next_flags(int w, logic [19:0] ins,
                                            logic [3:0] f, logic [3:0] af);
    logic [3:0] cmd;
    logic ext;
    cmd = ins[12:9];
    ext = (w == 3);
    if (!passes(ins[19:16], f)) return f;
    if (!(ins[8] || (ext && cmd == 4'b1010))) return f;
    if (cmd == 4'b0000 || cmd == 4'b1100 || (ext && cmd == 4'b0001))
      return {af[3:2], f[1:0]};
    return af;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc_no, got, want);
    end
  endtask

  // af_sel[4] selects random ALUFlags; mr_waits >= 0 forces MEMREAD stalls.
  task automatic run_instr(input logic [19:0] ins, input logic [4:0] af_sel,
                           input int pct, input int mr_waits, input int rst_at);
    state_t path[$];
    state_t ph;
    int k, cyc, waited;
    logic rdy, rst;
    logic [3:0] af;
    k = 0; cyc = 0; waited = 0;
    path.push_back(FETCH);
    path.push_back(DECODE);
    case (ins[15:14])
      2'b00: begin
        path.push_back(ins[13] ? EXECI : EXECR);
        path.push_back(ALUWB);
      end
      2'b01: begin
        path.push_back(MEMADR);
        path.push_back(ins[8] ? MEMREAD : MEMWRITE);
        if (ins[8]) path.push_back(MEMWB);
      end
      2'b10: path.push_back(BRANCH);
      default: ;
    endcase
    instr = ins;
    while (k < path.size()) begin
      ph = path[k];
      rst = (cyc == rst_at);
      if (mr_waits >= 0) rdy = (ph != MEMREAD) || (waited >= mr_waits);
      else rdy = ($urandom_range(99) < pct);
      af = af_sel[4] ? 4'($urandom) : af_sel[3:0];
      reset = rst;
      mem_ready = rdy;
      alu_flags = af;
      q2.push_back(model(2, ph, ins, fl2, rdy, rst));
      q3.push_back(model(3, ph, ins, fl3, rdy, rst));
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        fl2 = 4'h0;
        fl3 = 4'h0;
        reset = 1'b0;
        break;
      end
      if (ph == EXECR || ph == EXECI) begin
        fl2 = next_flags(2, ins, fl2, af);
        fl3 = next_flags(3, ins, fl3, af);
      end
      if (ph == MEMREAD && !rdy) waited++;
      if (!((ph == FETCH || ph == MEMREAD || ph == MEMWRITE) && !rdy)) k++;
    end
  endtask

  initial begin : monitor
    obs_t e2, e3;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        e3 = q3.pop_front();
        check("alu2", act2, e2);
        check("alu3", act3, e3);
        cyc_no++;
      end
    end
  end

  initial begin : stim
    logic [19:0] ins;
    int rst_at;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      reset = 1'b1;
      q2.push_back(model(2, FETCH, instr, fl2, 1'b1, 1'b1));
      q3.push_back(model(3, FETCH, instr, fl3, 1'b1, 1'b1));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    fl2 = 4'h0;
    fl3 = 4'h0;
    run_instr(20'hE0855, 5'h00, 100, -1, -1);
    run_instr(20'hE2537, 5'h04, 100, -1, -1);
    run_instr(20'h00855, 5'h00, 100, -1, -1);
    run_instr(20'h10855, 5'h00, 100, -1, -1);
    run_instr(20'hE5902, 5'h00, 100, 3, -1);
    run_instr(20'hE5837, 5'h00, 100, -1, -1);
    run_instr(20'hEA000, 5'h00, 100, -1, -1);
    run_instr(20'hE2537, 5'h00, 100, -1, -1);
    run_instr(20'h0A000, 5'h00, 100, -1, -1);
    run_instr(20'hE0255, 5'h1F, 100, -1, -1);
    run_instr(20'hE2537, 5'h04, 100, -1, -1);
    run_instr(20'hE5902, 5'h00, 100, 3, 4);
    run_instr(20'h00855, 5'h00, 100, -1, -1);
    for (int n = 0; n < 400; n++) begin
      ins = 20'($urandom);
      if ($urandom_range(99) < 80) ins[19:16] = 4'hE;
      rst_at = ($urandom_range(19) == 0) ? int'($urandom_range(6)) : -1;
      run_instr(ins, 5'h10, 70, -1, rst_at);
    end
    for (int i = 0; i < 10 && q2.size() > 0; i++) @(posedge clk);
    if (q2.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
